// File: rtl/rv32_pkg.sv
// Shared RV32 register-file types and constants for the operand-fetch slice.
package rv32_pkg;

    typedef logic [4:0]  reg_addr_t;
    typedef logic [31:0] word_t;

    localparam int        NUM_REGS = 32;
    localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/operand_fetch_if.sv
// Bus bundle between decode, register file, writeback and execute around operand_fetch.
// Handshakes: a transfer happens on a rising edge where valid & ready are both high; valid must not depend on ready.
interface operand_fetch_if
    import rv32_pkg::*;
#(
    parameter int SIDE_W = 64
);
    logic              in_valid;
    logic              in_ready;
    reg_addr_t         in_rs1;
    reg_addr_t         in_rs2;
    reg_addr_t         in_rd;
    logic              in_rd_we;
    logic [SIDE_W-1:0] in_side;

    reg_addr_t         rf_rd_addr0;
    reg_addr_t         rf_rd_addr1;
    word_t             rf_rd_data0;
    word_t             rf_rd_data1;

    logic              wb_ena;
    reg_addr_t         wb_addr;
    word_t             wb_data;
    logic              rf_wr_ena;
    reg_addr_t         rf_wr_addr;
    word_t             rf_wr_data;

    logic              flush;
    logic              out_valid;
    logic              out_ready;
    word_t             out_rs1_data;
    word_t             out_rs2_data;
    reg_addr_t         out_rd;
    logic              out_rd_we;
    logic [SIDE_W-1:0] out_side;

    logic [NUM_REGS-1:0] dbg_pending;

    modport slave (
        input  in_valid, in_rs1, in_rs2, in_rd, in_rd_we, in_side,
        input  rf_rd_data0, rf_rd_data1,
        input  wb_ena, wb_addr, wb_data,
        input  flush, out_ready,
        output in_ready, rf_rd_addr0, rf_rd_addr1,
        output rf_wr_ena, rf_wr_addr, rf_wr_data,
        output out_valid, out_rs1_data, out_rs2_data, out_rd, out_rd_we, out_side,
        output dbg_pending
    );

    modport master (
        output in_valid, in_rs1, in_rs2, in_rd, in_rd_we, in_side,
        output rf_rd_data0, rf_rd_data1,
        output wb_ena, wb_addr, wb_data,
        output flush, out_ready,
        input  in_ready, rf_rd_addr0, rf_rd_addr1,
        input  rf_wr_ena, rf_wr_addr, rf_wr_data,
        input  out_valid, out_rs1_data, out_rs2_data, out_rd, out_rd_we, out_side,
        input  dbg_pending
    );

endinterface

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, x0 never pending.
module reg_scoreboard
    import rv32_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                set_en,
    input  reg_addr_t           set_addr,
    input  logic                clr_en,
    input  reg_addr_t           clr_addr,
    input  reg_addr_t           q_rs1,
    input  reg_addr_t           q_rs2,
    input  reg_addr_t           q_rd,
    output logic                p_rs1,
    output logic                p_rs2,
    output logic                p_rd,
    output logic [NUM_REGS-1:0] pending
);

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;

    // Clear is applied before set so an issue and a writeback to the same register leave it pending.
    always_comb begin
        pending_d = pending_q;
        if (clr_en) pending_d[clr_addr] = 1'b0;
        if (set_en) pending_d[set_addr] = 1'b1;
        pending_d[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) pending_q <= '0;
        else      pending_q <= pending_d;
    end

    assign p_rs1   = pending_q[q_rs1];
    assign p_rs2   = pending_q[q_rs2];
    assign p_rd    = pending_q[q_rd];
    assign pending = pending_q;

endmodule

// File: rtl/operand_fetch.sv
// RV32 operand-fetch stage: RF read, RAW/WAW scoreboard stall, output pipeline register, writeback relay.
// Optional macro WB_BYPASS_EN forwards same-cycle writeback data into the source operands.
module operand_fetch
    import rv32_pkg::*;
#(
    parameter int SIDE_W = 64
)(
    input  logic           clk,
    input  logic           rst,
    operand_fetch_if.slave bus
);

    logic              out_valid_q;
    word_t             out_rs1_q;
    word_t             out_rs2_q;
    reg_addr_t         out_rd_q;
    logic              out_rd_we_q;
    logic [SIDE_W-1:0] out_side_q;

    logic p_rs1, p_rs2, p_rd;
    logic byp_rs1, byp_rs2;
    logic busy_rs1, busy_rs2, busy_rd;
    logic hazard, accept, issue;
    word_t opnd0, opnd1;

`ifdef WB_BYPASS_EN
    assign byp_rs1 = bus.wb_ena && (bus.wb_addr == bus.in_rs1) && (bus.in_rs1 != REG_ZERO);
    assign byp_rs2 = bus.wb_ena && (bus.wb_addr == bus.in_rs2) && (bus.in_rs2 != REG_ZERO);
`else
    assign byp_rs1 = 1'b0;
    assign byp_rs2 = 1'b0;
`endif

    // The instruction sitting in the output register has not set its pending bit yet, so match it directly.
    assign busy_rs1 = (bus.in_rs1 != REG_ZERO) &&
                      ((p_rs1 && !byp_rs1) || (out_valid_q && out_rd_we_q && out_rd_q == bus.in_rs1));
    assign busy_rs2 = (bus.in_rs2 != REG_ZERO) &&
                      ((p_rs2 && !byp_rs2) || (out_valid_q && out_rd_we_q && out_rd_q == bus.in_rs2));
    assign busy_rd  = (bus.in_rd != REG_ZERO) &&
                      (p_rd || (out_valid_q && out_rd_we_q && out_rd_q == bus.in_rd));

    assign hazard       = busy_rs1 || busy_rs2 || (bus.in_rd_we && busy_rd);
    assign bus.in_ready = rst && !hazard && (!out_valid_q || bus.out_ready) && !bus.flush;
    assign accept       = bus.in_valid && bus.in_ready;
    assign issue        = out_valid_q && bus.out_ready && !bus.flush;

    assign bus.rf_rd_addr0 = bus.in_rs1;
    assign bus.rf_rd_addr1 = bus.in_rs2;

    assign opnd0 = (bus.in_rs1 == REG_ZERO) ? '0 : (byp_rs1 ? bus.wb_data : bus.rf_rd_data0);
    assign opnd1 = (bus.in_rs2 == REG_ZERO) ? '0 : (byp_rs2 ? bus.wb_data : bus.rf_rd_data1);

    assign bus.rf_wr_ena  = bus.wb_ena && (bus.wb_addr != REG_ZERO);
    assign bus.rf_wr_addr = bus.wb_addr;
    assign bus.rf_wr_data = bus.wb_data;

    reg_scoreboard u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (issue && out_rd_we_q),
        .set_addr (out_rd_q),
        .clr_en   (bus.wb_ena),
        .clr_addr (bus.wb_addr),
        .q_rs1    (bus.in_rs1),
        .q_rs2    (bus.in_rs2),
        .q_rd     (bus.in_rd),
        .p_rs1    (p_rs1),
        .p_rs2    (p_rs2),
        .p_rd     (p_rd),
        .pending  (bus.dbg_pending)
    );

    // Data fields only change on accept, which keeps them stable under backpressure.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_rs1_q   <= '0;
            out_rs2_q   <= '0;
            out_rd_q    <= '0;
            out_rd_we_q <= 1'b0;
            out_side_q  <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_rs1_q   <= opnd0;
            out_rs2_q   <= opnd1;
            out_rd_q    <= bus.in_rd;
            out_rd_we_q <= bus.in_rd_we && (bus.in_rd != REG_ZERO);
            out_side_q  <= bus.in_side;
        end else if (issue || bus.flush) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid    = out_valid_q;
    assign bus.out_rs1_data = out_rs1_q;
    assign bus.out_rs2_data = out_rs2_q;
    assign bus.out_rd       = out_rd_q;
    assign bus.out_rd_we    = out_rd_we_q;
    assign bus.out_side     = out_side_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: register-file model, per-scenario tasks, summary line.
module tb_operand_fetch;
    import rv32_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    logic [63:0] exp_q[$];
    logic [63:0] exp_side;

    word_t rf [NUM_REGS];

    operand_fetch_if #(.SIDE_W(64)) bus ();

    operand_fetch #(.SIDE_W(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file model: x0 holds junk so the stage's zero forcing is visible.
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) rf[i] <= 32'h1000 + 32'(i);
            rf[0] <= 32'hFFFF_FFFF;
            rf[5] <= 32'h0000_1234;
        end else if (bus.rf_wr_ena) begin
            rf[bus.rf_wr_addr] <= bus.rf_wr_data;
        end
    end
    assign bus.rf_rd_data0 = rf[bus.rf_rd_addr0];
    assign bus.rf_rd_data1 = rf[bus.rf_rd_addr1];

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive_in(input logic v, input reg_addr_t rs1, input reg_addr_t rs2,
                            input reg_addr_t rd, input logic we, input logic [63:0] side);
        bus.in_valid = v;
        bus.in_rs1   = rs1;
        bus.in_rs2   = rs2;
        bus.in_rd    = rd;
        bus.in_rd_we = we;
        bus.in_side  = side;
    endtask

    task automatic drive_wb(input logic ena, input reg_addr_t addr, input word_t data);
        bus.wb_ena  = ena;
        bus.wb_addr = addr;
        bus.wb_data = data;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive_in(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 64'h0);
        tick();
        tick();
        n_checks++;
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b want=0", bus.in_ready); end
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
        n_checks++;
        if (bus.out_rs1_data !== 32'h0 || bus.out_rd !== 5'd0 || bus.out_side !== 64'h0) begin
            n_fail++; $display("FAIL reset_out_data rs1=%h rd=%0d side=%h want zeros", bus.out_rs1_data, bus.out_rd, bus.out_side);
        end
        drive_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 64'h0);
        rst = 1'b1;
        tick();
        n_checks++;
        if (bus.dbg_pending !== 32'h0) begin n_fail++; $display("FAIL reset_pending got=%h want=0", bus.dbg_pending); end
        drive_in(1'b0, 5'd9, 5'd10, 5'd11, 1'b1, 64'h0);
        settle();
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready got=%b want=1", bus.in_ready); end
        drive_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 64'h0);
    endtask

    task automatic test_basic_issue();
        bus.out_ready = 1'b0;
        drive_in(1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 64'hDEAD_BEEF_0000_0001);
        settle();
        n_checks++;
        if (bus.rf_rd_addr0 !== 5'd5 || bus.rf_rd_addr1 !== 5'd0) begin
            n_fail++; $display("FAIL basic_rd_addr got=%0d/%0d want=5/0", bus.rf_rd_addr0, bus.rf_rd_addr1);
        end
        tick();
        drive_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 64'h0);
        settle();
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_rs1_data !== 32'h1234 || bus.out_rs2_data !== 32'h0) begin
            n_fail++; $display("FAIL basic_operands v=%b rs1=%h rs2=%h want 1/00001234/00000000",
                               bus.out_valid, bus.out_rs1_data, bus.out_rs2_data);
        end
        n_checks++;
        if (bus.out_side !== 64'hDEAD_BEEF_0000_0001) begin
            n_fail++; $display("FAIL basic_side got=%h want=deadbeef00000001", bus.out_side);
        end
        bus.out_ready = 1'b1;
        tick();
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain got=%b want=0", bus.out_valid); end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_raw_stall();
        bus.out_ready = 1'b1;
        drive_in(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 64'h7);
        settle();
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL raw_first_ready got=%b want=1", bus.in_ready); end
        tick();
        drive_in(1'b1, 5'd7, 5'd0, 5'd8, 1'b0, 64'h8);
        settle();
        n_checks++;
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL raw_outreg_hazard got=%b want=0", bus.in_ready); end
        tick();
        n_checks++;
        if (bus.dbg_pending !== 32'h0000_0080 || bus.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL raw_pending got=%h ready=%b want=00000080/0", bus.dbg_pending, bus.in_ready);
        end
        tick();
        n_checks++;
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL raw_stall_holds got=%b want=0", bus.in_ready); end
        drive_wb(1'b1, 5'd7, 32'hAA);
        settle();
`ifdef WB_BYPASS_EN
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL raw_bypass_ready got=%b want=1", bus.in_ready); end
        tick();
        drive_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 64'h0);
        drive_wb(1'b0, 5'd0, 32'h0);
        settle();
`else
        n_checks++;
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL raw_wb_cycle_ready got=%b want=0", bus.in_ready); end
        tick();
        drive_wb(1'b0, 5'd0, 32'h0);
        settle();
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL raw_after_wb_ready got=%b want=1", bus.in_ready); end
        tick();
        drive_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 64'h0);
        settle();
`endif
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_rs1_data !== 32'hAA) begin
            n_fail++; $display("FAIL raw_operand v=%b rs1=%h want 1/000000aa", bus.out_valid, bus.out_rs1_data);
        end
        tick();
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.dbg_pending !== 32'h0) begin
            n_fail++; $display("FAIL raw_drain v=%b pend=%h want 0/0", bus.out_valid, bus.dbg_pending);
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_waw();
        bus.out_ready = 1'b0;
        drive_in(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 64'h3);
        tick();
        settle();
        n_checks++;
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL waw_held_ready got=%b want=0", bus.in_ready); end
        bus.out_ready = 1'b1;
        settle();
        n_checks++;
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL waw_outreg_hazard got=%b want=0", bus.in_ready); end
        tick();
        n_checks++;
        if (bus.in_ready !== 1'b0 || bus.dbg_pending !== 32'h0000_0008) begin
            n_fail++; $display("FAIL waw_pending ready=%b pend=%h want 0/00000008", bus.in_ready, bus.dbg_pending);
        end
        drive_wb(1'b1, 5'd3, 32'h33);
        settle();
        n_checks++;
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL waw_wb_cycle_ready got=%b want=0", bus.in_ready); end
        tick();
        drive_wb(1'b0, 5'd0, 32'h0);
        settle();
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL waw_after_wb_ready got=%b want=1", bus.in_ready); end
        tick();
        drive_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 64'h0);
        settle();
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_rd !== 5'd3 || bus.out_rd_we !== 1'b1) begin
            n_fail++; $display("FAIL waw_out v=%b rd=%0d we=%b want 1/3/1", bus.out_valid, bus.out_rd, bus.out_rd_we);
        end
        tick();
        bus.out_ready = 1'b0;
        drive_wb(1'b1, 5'd3, 32'h34);
        tick();
        drive_wb(1'b0, 5'd0, 32'h0);
        settle();
        n_checks++;
        if (bus.dbg_pending !== 32'h0) begin n_fail++; $display("FAIL waw_final_pending got=%h want=0", bus.dbg_pending); end
    endtask

    task automatic test_backpressure_flush();
        bus.out_ready = 1'b0;
        drive_in(1'b1, 5'd5, 5'd0, 5'd9, 1'b1, 64'h0123_4567_89AB_CDEF);
        tick();
        drive_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 64'h0);
        for (int c = 0; c < 4; c++) begin
            settle();
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_rd !== 5'd9 || bus.out_rs1_data !== 32'h1234 ||
                bus.out_side !== 64'h0123_4567_89AB_CDEF) begin
                n_fail++; $display("FAIL hold_stable cyc=%0d v=%b rd=%0d rs1=%h side=%h", c,
                                   bus.out_valid, bus.out_rd, bus.out_rs1_data, bus.out_side);
            end
            tick();
        end
        bus.flush     = 1'b1;
        bus.out_ready = 1'b1;
        settle();
        n_checks++;
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready got=%b want=0", bus.in_ready); end
        tick();
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        settle();
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.dbg_pending !== 32'h0) begin
            n_fail++; $display("FAIL flush_result v=%b pend=%h want 0/0", bus.out_valid, bus.dbg_pending);
        end
    endtask

    task automatic test_back_to_back_x0();
        bus.out_ready = 1'b1;
        drive_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 64'hA1);
        settle();
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL x0_first_ready got=%b want=1", bus.in_ready); end
        tick();
        exp_q.push_back(64'hA1);
        drive_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 64'hA2);
        settle();
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b1 || bus.out_rd_we !== 1'b0) begin
            n_fail++; $display("FAIL x0_second_ready ready=%b v=%b we=%b want 1/1/0", bus.in_ready, bus.out_valid, bus.out_rd_we);
        end
        exp_side = exp_q.pop_front();
        n_checks++;
        if (bus.out_side !== exp_side) begin n_fail++; $display("FAIL x0_side1 got=%h want=%h", bus.out_side, exp_side); end
        tick();
        exp_q.push_back(64'hA2);
        drive_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 64'h0);
        settle();
        exp_side = exp_q.pop_front();
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_side !== exp_side || bus.out_rs1_data !== 32'h0) begin
            n_fail++; $display("FAIL x0_side2 v=%b side=%h rs1=%h want 1/%h/0", bus.out_valid, bus.out_side, bus.out_rs1_data, exp_side);
        end
        tick();
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.dbg_pending !== 32'h0) begin
            n_fail++; $display("FAIL x0_drain v=%b pend=%h want 0/0", bus.out_valid, bus.dbg_pending);
        end
        drive_wb(1'b1, 5'd0, 32'h55);
        settle();
        n_checks++;
        if (bus.rf_wr_ena !== 1'b0) begin n_fail++; $display("FAIL x0_wb_relay got=%b want=0", bus.rf_wr_ena); end
        drive_wb(1'b1, 5'd4, 32'h55);
        settle();
        n_checks++;
        if (bus.rf_wr_ena !== 1'b1 || bus.rf_wr_addr !== 5'd4 || bus.rf_wr_data !== 32'h55) begin
            n_fail++; $display("FAIL wb_relay en=%b addr=%0d data=%h want 1/4/00000055", bus.rf_wr_ena, bus.rf_wr_addr, bus.rf_wr_data);
        end
        tick();
        drive_wb(1'b0, 5'd0, 32'h0);
        settle();
        n_checks++;
        if (bus.dbg_pending !== 32'h0) begin n_fail++; $display("FAIL wb_nonpending got=%h want=0", bus.dbg_pending); end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_mid_reset();
        bus.out_ready = 1'b1;
        drive_in(1'b1, 5'd0, 5'd0, 5'd10, 1'b1, 64'hB0);
        tick();
        drive_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 64'h0);
        rst = 1'b0;
        drive_wb(1'b1, 5'd6, 32'h66);
        settle();
        n_checks++;
        if (bus.rf_wr_ena !== 1'b1 || bus.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL midrst_comb wr_ena=%b ready=%b want 1/0", bus.rf_wr_ena, bus.in_ready);
        end
        tick();
        rst = 1'b1;
        drive_wb(1'b0, 5'd0, 32'h0);
        settle();
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.dbg_pending !== 32'h0) begin
            n_fail++; $display("FAIL midrst_state v=%b pend=%h want 0/0", bus.out_valid, bus.dbg_pending);
        end
        bus.out_ready = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        drive_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 64'h0);
        drive_wb(1'b0, 5'd0, 32'h0);
        test_reset();
        test_basic_issue();
        test_raw_stall();
        test_waw();
        test_backpressure_flush();
        test_back_to_back_x0();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
